// File: rtl/fetch_decode_queue.sv
// In-order {word PC, instruction} queue between fetch and decode; flush drops all wrong-path entries.
// 1-cycle push-to-head latency (0 with FDQ_BYPASS_EN on an empty queue); in_ready depends only on occupancy.
module fetch_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32,
    parameter int PC_W   = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    input  logic              out_ready,
    input  logic              flush,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_instr_mem [DEPTH];
    logic [PC_W-1:0]   r_pc_mem    [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_byp;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_FULL);

`ifdef FDQ_BYPASS_EN
    assign w_byp = w_empty & in_valid & ~flush;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_pop  = ~w_empty & out_ready;
    assign w_push = in_valid & ~w_full & ~(w_byp & out_ready);

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty | w_byp;
    assign count     = r_count;

    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (w_byp) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end else if (!w_empty) begin
            out_instr = r_instr_mem[r_rd_ptr];
            out_pc    = r_pc_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
        end
    end

endmodule
